// File: rtl/dp_axi_polyvec_loader_pkg.sv
// Shared constants for the polyvec loader slice.
//   LD_IDLE / LD_LOAD / LD_DONE : loader FSM state encodings
//   DEF_POLY_WORDS              : default beats per poly
//   cnt_width()                 : counter width for a modulus, never below 1 bit
package dp_axi_polyvec_loader_pkg;

  localparam logic [1:0] LD_IDLE = 2'd0;
  localparam logic [1:0] LD_LOAD = 2'd1;
  localparam logic [1:0] LD_DONE = 2'd2;

  localparam int DEF_POLY_WORDS = 512;

  // A counter that only ever holds 0 still needs one bit to exist.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dp_axi_polyvec_loader_if.sv
// Coefficient stream in plus bank-parallel write port out, bundled as one bus.
//   s_axis_tvalid/tready/tdata/tlast : beat stream, lane b of tdata feeds bank b
//   o_axi_we     : NUM_BASE_BANK*NUM_POLY write enables, poly-major
//   o_axi_wraddr : per-bank address, all lanes equal
//   o_axi_data   : per-bank write data
// Modports:
//   slave  : the loader (sinks the stream, drives the write port)
//   master : the beat source and the buffer being written
interface dp_axi_polyvec_loader_if #(
  parameter int COE_WIDTH     = 39,
  parameter int ADDR_WIDTH    = 9,
  parameter int NUM_POLY      = 3,
  parameter int NUM_BASE_BANK = 8
);

  logic                                s_axis_tvalid;
  logic                                s_axis_tready;
  logic [COE_WIDTH*NUM_BASE_BANK-1:0]  s_axis_tdata;
  logic                                s_axis_tlast;
  logic [NUM_BASE_BANK*NUM_POLY-1:0]   o_axi_we;
  logic [ADDR_WIDTH*NUM_BASE_BANK-1:0] o_axi_wraddr;
  logic [COE_WIDTH*NUM_BASE_BANK-1:0]  o_axi_data;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
    output s_axis_tready, o_axi_we, o_axi_wraddr, o_axi_data
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
    input  s_axis_tready, o_axi_we, o_axi_wraddr, o_axi_data
  );

endinterface

// File: rtl/dp_load_addr_gen.sv
// Nested word/poly counter for the polyvec loader.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart at word 0 of poly 0 (wins over adv)
//   adv        : step one word; the word count wraps into the poly count
//   addr, poly : current word address and poly index
//   last_word  : addr is the final word of a poly
//   last_poly  : poly is the final poly of the polyvec
module dp_load_addr_gen #(
  parameter int POLY_WORDS = 512,
  parameter int NUM_POLY   = 3,
  parameter int AW         = 9,
  parameter int PW         = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [AW-1:0] addr,
  output logic [PW-1:0] poly,
  output logic          last_word,
  output logic          last_poly
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(POLY_WORDS - 1);
  localparam logic [PW-1:0] LAST_POLY = PW'(NUM_POLY - 1);

  // With POLY_WORDS==1 addr is stuck at 0, last_word is always true and
  // every advance moves on to the next poly.
  assign last_word = (addr == LAST_ADDR);
  assign last_poly = (poly == LAST_POLY);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      poly <= '0;
    end else if (clr) begin
      addr <= '0;
      poly <= '0;
    end else if (adv) begin
      if (last_word) begin
        addr <= '0;
        poly <= last_poly ? '0 : poly + PW'(1);
      end else begin
        addr <= addr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/dp_axi_polyvec_loader.sv
// Feeds the triple ping-pong polyvec buffer: one accepted beat becomes one
// registered bank-parallel write, polys filled in order, then a one-cycle
// o_done rotates the buffer strictly after the last write has landed.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_start    : request to load one polyvec (ignored while busy)
//   bus        : beat stream in, bank write port out (slave side)
//   o_done     : one-cycle pulse, polyvec fully written
//   o_busy     : from accepted start through the o_done cycle
//   o_err      : sticky framing error (tlast off the final beat, or missing)
module dp_axi_polyvec_loader
  import dp_axi_polyvec_loader_pkg::*;
#(
  parameter int COE_WIDTH     = 39,
  parameter int ADDR_WIDTH    = 9,
  parameter int POLY_WORDS    = DEF_POLY_WORDS,
  parameter int NUM_POLY      = 3,
  parameter int NUM_BASE_BANK = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  dp_axi_polyvec_loader_if.slave  bus,
  output logic                    o_done,
  output logic                    o_busy,
  output logic                    o_err
);

  localparam int AW   = cnt_width(POLY_WORDS);
  localparam int PW   = cnt_width(NUM_POLY);
  localparam int WE_W = NUM_BASE_BANK * NUM_POLY;

  localparam logic [WE_W-1:0] BANK_ONES = WE_W'({NUM_BASE_BANK{1'b1}});

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [AW-1:0] addr_cnt;
  logic [PW-1:0] poly_cnt;
  logic          last_word;
  logic          last_poly;
  logic          start_ok;
  logic          hs;
  logic          final_beat;

  // A start landing on the o_done cycle is dropped so the downstream edge
  // detector always sees o_done low between pulses.
  assign start_ok   = (state == LD_IDLE) && i_start && !o_done;
  assign hs         = (state == LD_LOAD) && bus.s_axis_tvalid;
  assign final_beat = last_word && last_poly;

  assign bus.s_axis_tready = (state == LD_LOAD);
  assign o_busy            = (state != LD_IDLE) || o_done;

  dp_load_addr_gen #(
    .POLY_WORDS (POLY_WORDS),
    .NUM_POLY   (NUM_POLY),
    .AW         (AW),
    .PW         (PW)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_ok),
    .adv       (hs),
    .addr      (addr_cnt),
    .poly      (poly_cnt),
    .last_word (last_word),
    .last_poly (last_poly)
  );

  // Termination is by count only; tlast feeds nothing but the error flag.
  always_comb begin
    // NOTE: default first so no branch leaves state_next unassigned, which
    // would otherwise infer a latch.
    state_next = state;
    case (state)
      LD_IDLE: if (start_ok)         state_next = LD_LOAD;
      LD_LOAD: if (hs && final_beat) state_next = LD_DONE;
      LD_DONE:                       state_next = LD_IDLE;
      default:                       state_next = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the wide wraddr/data registers are reset too: an abandoned load
      // must leave every output at 0, so this datapath is not reset-free.
      state            <= LD_IDLE;
      o_done           <= 1'b0;
      o_err            <= 1'b0;
      bus.o_axi_we     <= '0;
      bus.o_axi_wraddr <= '0;
      bus.o_axi_data   <= '0;
    end else begin
      state  <= state_next;
      // Registered off DONE, so the pulse trails the last write by a cycle.
      o_done <= (state == LD_DONE);

      bus.o_axi_we <= hs ? (BANK_ONES << (poly_cnt * NUM_BASE_BANK)) : '0;
      // Gap cycles hold address and data; only the enables drop.
      if (hs) begin
        bus.o_axi_wraddr <= {NUM_BASE_BANK{ADDR_WIDTH'(addr_cnt)}};
        bus.o_axi_data   <= bus.s_axis_tdata;
      end

      if (start_ok) begin
        o_err <= 1'b0;
      end else if (hs && (bus.s_axis_tlast != final_beat)) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dp_axi_polyvec_loader.sv
// Self-checking bench for dp_axi_polyvec_loader: a beat-count model predicts
// every output each cycle, plus literal expectations for the named cases and
// a second instance with POLY_WORDS=1.
module tb_dp_axi_polyvec_loader;

  localparam int CW    = 39;
  localparam int AWD   = 9;
  localparam int PWDS  = 512;
  localparam int NP    = 3;
  localparam int NB    = 8;
  localparam int TOTAL = PWDS * NP;
  localparam int DW    = CW * NB;
  localparam int WEW   = NB * NP;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic i_start = 1'b0;
  logic start1  = 1'b0;
  logic o_done, o_busy, o_err;
  logic done1, busy1, err1;

  dp_axi_polyvec_loader_if #(.COE_WIDTH(CW), .ADDR_WIDTH(AWD), .NUM_POLY(NP), .NUM_BASE_BANK(NB)) bus ();
  dp_axi_polyvec_loader_if #(.COE_WIDTH(CW), .ADDR_WIDTH(AWD), .NUM_POLY(NP), .NUM_BASE_BANK(NB)) bus1 ();

  dp_axi_polyvec_loader #(
    .COE_WIDTH(CW), .ADDR_WIDTH(AWD), .POLY_WORDS(PWDS), .NUM_POLY(NP), .NUM_BASE_BANK(NB)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .bus(bus),
    .o_done(o_done), .o_busy(o_busy), .o_err(o_err)
  );

  dp_axi_polyvec_loader #(
    .COE_WIDTH(CW), .ADDR_WIDTH(AWD), .POLY_WORDS(1), .NUM_POLY(NP), .NUM_BASE_BANK(NB)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .bus(bus1),
    .o_done(done1), .o_busy(busy1), .o_err(err1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) d = (d << 32) | DW'($urandom);
    return d;
  endfunction

  // Lane b carries the beat index tagged with its lane number.
  function automatic logic [DW-1:0] seq_beat(input int idx);
    logic [DW-1:0] d;
    d = '0;
    for (int b = 0; b < NB; b++) d[b*CW +: CW] = CW'(idx) | (CW'(b) << 32);
    return d;
  endfunction

  // ---------------- behavioural model ----------------
  // The loader is a count of accepted beats: beat n of a load writes poly
  // n/PWDS at word n%PWDS; o_done follows two edges after the final beat.
  int              cyc = 0;
  int              start_edge = 0;
  bit              m_active = 1'b0;
  int              m_n = 0;
  int              m_age = 0;
  bit              start_now, beat_now;
  logic [WEW-1:0]  e_we = '0;
  logic [AWD-1:0]  e_addr = '0;
  logic [DW-1:0]   e_data = '0;
  bit              e_done = 1'b0;
  bit              e_err = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0; m_n = 0; m_age = 0;
      e_we = '0; e_addr = '0; e_data = '0; e_done = 1'b0; e_err = 1'b0;
    end else begin
      cyc++;
      start_now = i_start && !m_active;
      beat_now  = m_active && (m_n < TOTAL) && bus.s_axis_tvalid;
      e_done = 1'b0;
      e_we   = '0;
      if (m_active && m_n == TOTAL) begin
        m_age++;
        if (m_age == 1) e_done = 1'b1;
        else m_active = 1'b0;
      end
      if (start_now) begin
        m_active = 1'b1; m_n = 0; m_age = 0; e_err = 1'b0; start_edge = cyc;
      end
      if (beat_now) begin
        for (int b = 0; b < NB; b++) e_we[(m_n / PWDS) * NB + b] = 1'b1;
        e_addr = AWD'(m_n % PWDS);
        e_data = bus.s_axis_tdata;
        if (bus.s_axis_tlast != (m_n == TOTAL - 1)) e_err = 1'b1;
        m_n++;
      end
    end
  end

  // ---------------- compare + write log ----------------
  logic [WEW-1:0] we_log   [TOTAL];
  logic [AWD-1:0] addr_log [TOTAL];
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_edge = 0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("tready", bus.s_axis_tready, m_active && (m_n < TOTAL));
      check("we",     bus.o_axi_we,      e_we);
      check("wraddr", bus.o_axi_wraddr,  {NB{e_addr}});
      check("data",   bus.o_axi_data,    e_data);
      check("done",   o_done,            e_done);
      check("busy",   o_busy,            m_active);
      check("err",    o_err,             e_err);
      if (|bus.o_axi_we && wr_cnt < TOTAL) begin
        we_log[wr_cnt]   = bus.o_axi_we;
        addr_log[wr_cnt] = bus.o_axi_wraddr[AWD-1:0];
        wr_cnt++;
      end
      if (o_done) begin
        done_cnt++;
        done_edge = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called and returns at a negedge with the DUT idle.
  task automatic run_load(input int gap_pct, input int tlast_beat, input bit seq_data,
                          input int glitch_beat, input bit glitch_done, input int rst_beat);
    int idx, c;
    bit glitched, aborted;
    idx = 0; c = 0; glitched = 1'b0; aborted = 1'b0;
    wr_cnt = 0; done_cnt = 0;
    bus.s_axis_tlast = 1'b0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("err_clear_on_start", o_err, 1'b0);
    check("tready_after_start", bus.s_axis_tready, 1'b1);
    while (idx < TOTAL && c < 20000) begin
      if (idx == rst_beat) begin
        #2 rst_n = 1'b0;
        #1;
        check("arst_we",     bus.o_axi_we,      '0);
        check("arst_wraddr", bus.o_axi_wraddr,  '0);
        check("arst_data",   bus.o_axi_data,    '0);
        check("arst_tready", bus.s_axis_tready, 1'b0);
        check("arst_busy",   o_busy,            1'b0);
        check("arst_done",   o_done,            1'b0);
        check("arst_err",    o_err,             1'b0);
        aborted = 1'b1;
        break;
      end
      bus.s_axis_tvalid = ($urandom_range(99) >= gap_pct);
      bus.s_axis_tdata  = seq_data ? seq_beat(idx) : rand_data();
      bus.s_axis_tlast  = (idx == tlast_beat);
      i_start = (idx == glitch_beat) && !glitched;
      if (i_start) glitched = 1'b1;
      if (bus.s_axis_tvalid && bus.s_axis_tready) idx++;
      @(negedge clk);
      c++;
    end
    if (aborted) begin
      bus.s_axis_tvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("no_done_after_abort", done_cnt, 0);
    end else begin
      check("load_within_budget", c < 20000, 1'b1);
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
      i_start = glitch_done;           // DONE cycle, then the o_done cycle
      repeat (2) @(negedge clk);
      i_start = 1'b0;
      bus.s_axis_tvalid = 1'b1;        // beats offered while idle are refused
      bus.s_axis_tdata  = rand_data();
      repeat (5) @(negedge clk);
      check("done_pulses", done_cnt, 1);
      check("write_count", wr_cnt, TOTAL);
    end
  endtask

  logic [WEW-1:0] pw1_we [3] = '{24'h0000FF, 24'h00FF00, 24'hFF0000};

  initial begin
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.s_axis_tlast = 1'b0;
    bus1.s_axis_tvalid = 1'b0; bus1.s_axis_tdata = '0; bus1.s_axis_tlast = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tready", bus.s_axis_tready, 1'b0);
    check("rst_we",     bus.o_axi_we,      '0);
    check("rst_wraddr", bus.o_axi_wraddr,  '0);
    check("rst_data",   bus.o_axi_data,    '0);
    check("rst_done",   o_done,            1'b0);
    check("rst_busy",   o_busy,            1'b0);
    check("rst_err",    o_err,             1'b0);
    check("rst1_we",    bus1.o_axi_we,     '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back beats carrying their index.
    run_load(0, TOTAL - 1, 1'b1, -1, 1'b0, -1);
    check("beat0_we",      we_log[0],    24'h0000FF);
    check("beat0_addr",    addr_log[0],  0);
    check("beat512_we",    we_log[512],  24'h00FF00);
    check("beat512_addr",  addr_log[512], 0);
    check("beat1535_we",   we_log[1535], 24'hFF0000);
    check("beat1535_addr", addr_log[1535], 511);
    check("done_latency",  done_edge - start_edge, 1537);
    check("no_err_clean",  o_err, 1'b0);

    run_load(50, TOTAL - 1, 1'b0, -1, 1'b0, -1);

    // tlast early and missing on the final beat.
    run_load(30, 700, 1'b0, -1, 1'b0, -1);
    check("err_sticky", o_err, 1'b1);

    // Starts during LOAD and across DONE/o_done are ignored.
    run_load(20, TOTAL - 1, 1'b0, 100, 1'b1, -1);
    check("err_after_clean_load", o_err, 1'b0);

    run_load(10, TOTAL - 1, 1'b0, -1, 1'b0, 800);
    run_load(0, TOTAL - 1, 1'b0, -1, 1'b0, -1);
    check("reload_we0",   we_log[0],   24'h0000FF);
    check("reload_addr0", addr_log[0], 0);

    // POLY_WORDS=1 instance: three beats, one per poly.
    bus.s_axis_tvalid = 1'b0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("pw1_tready", bus1.s_axis_tready, 1'b1);
    bus1.s_axis_tvalid = 1'b1;
    bus1.s_axis_tdata  = seq_beat(40);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("pw1_we",     bus1.o_axi_we,     pw1_we[k]);
      check("pw1_wraddr", bus1.o_axi_wraddr, '0);
      check("pw1_data",   bus1.o_axi_data,   seq_beat(40 + k));
      check("pw1_done_early", done1, 1'b0);
      if (k < 2) begin
        bus1.s_axis_tdata = seq_beat(41 + k);
        bus1.s_axis_tlast = (k == 1);
      end else begin
        bus1.s_axis_tvalid = 1'b0;
        bus1.s_axis_tlast  = 1'b0;
      end
    end
    @(negedge clk);
    check("pw1_done",      done1, 1'b1);
    check("pw1_busy_done", busy1, 1'b1);
    check("pw1_we_idle",   bus1.o_axi_we, '0);
    @(negedge clk);
    check("pw1_done_low",  done1, 1'b0);
    check("pw1_busy_low",  busy1, 1'b0);
    check("pw1_err",       err1,  1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
